// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
//
// Purpose:
//   Receives a program image as a byte stream and writes it, one 16-bit word
//   at a time, into the program port of an instruction RAM. The CPU is held
//   in reset until a load completes successfully.
//
//   Stream format: length byte L (1..MAX_WORDS), then L words sent as a high
//   byte (opcode) followed by a low byte (operand), then an optional
//   checksum byte.
//
// Configuration:
//   LOADER_CHECKSUM_EN - when defined, every word byte is summed mod 256 and
//                        one trailing checksum byte must match that sum
//                        before the load is reported done. When undefined,
//                        the checksum logic is absent and the last write
//                        completes the load.
//
// Parameters:
//   BASE_ADDR  - RAM address of the first program word (wraps at 255 -> 0)
//   MAX_WORDS  - largest legal program length, 1..16
//
// Ports:
//   i_clock            system clock, rising edge
//   i_reset            synchronous active-low reset
//   i_start            begin a session (honoured only in IDLE, DONE, ERROR)
//   i_byte_valid       source presents a byte on i_byte
//   i_byte[7:0]        stream byte
//   o_byte_ready       loader accepts i_byte this cycle
//   o_program_mode     RAM program-port select, high during a session
//   o_program_address  RAM program address
//   o_program_data     {opcode, operand} word to write
//   o_write_enable     one-cycle RAM write strobe
//   o_cpu_hold         keeps the CPU in reset (high except after success)
//   o_done             load completed successfully
//   o_error            load aborted
// -----------------------------------------------------------------------------
module program_loader #(
    parameter logic [7:0] BASE_ADDR = 8'd0,
    parameter int         MAX_WORDS = 16
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    output logic        o_byte_ready,
    output logic        o_program_mode,
    output logic [7:0]  o_program_address,
    output logic [15:0] o_program_data,
    output logic        o_write_enable,
    output logic        o_cpu_hold,
    output logic        o_done,
    output logic        o_error
);

    localparam logic [7:0] MAX_LEN = 8'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_HIGH  = 3'd2,
        S_LOW   = 3'd3,
        S_WRITE = 3'd4,
`ifdef LOADER_CHECKSUM_EN
        S_CHECK = 3'd5,
`endif
        S_DONE  = 3'd6,
        S_ERROR = 3'd7
    } state_t;

    state_t      r_state;
    logic        r_byte_ready;
    logic        r_program_mode;
    logic [7:0]  r_program_address;
    logic [15:0] r_program_data;
    logic        r_write_enable;
    logic        r_cpu_hold;
    logic        r_done;
    logic        r_error;
    logic [7:0]  r_count;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  r_checksum;
`endif

    // A byte moves only when both sides agree on the same rising edge.
    logic w_accept;
    assign w_accept = i_byte_valid & r_byte_ready;

    // All outputs come straight from registers; o_byte_ready is updated
    // together with every state change so it always matches the new state.
    // NOTE: every register in this clocked block uses <= so all of them see
    // the values from before the edge, exactly like real flip-flops.
    always_ff @(posedge i_clock) begin
        // NOTE: reset is checked inside the clocked block, so it only takes
        // effect on a rising edge; it wins over every other transition,
        // including a write strobe that was about to be issued.
        if (!i_reset) begin
            r_state           <= S_IDLE;
            r_byte_ready      <= 1'b0;
            r_program_mode    <= 1'b0;
            r_program_address <= BASE_ADDR;
            r_program_data    <= 16'd0;
            r_write_enable    <= 1'b0;
            r_cpu_hold        <= 1'b1;
            r_done            <= 1'b0;
            r_error           <= 1'b0;
            r_count           <= 8'd0;
`ifdef LOADER_CHECKSUM_EN
            r_checksum        <= 8'd0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (i_start) begin
                        r_state           <= S_LEN;
                        r_byte_ready      <= 1'b1;
                        r_done            <= 1'b0;
                        r_error           <= 1'b0;
                        r_program_mode    <= 1'b1;
                        r_cpu_hold        <= 1'b1;
                        r_program_address <= BASE_ADDR;
`ifdef LOADER_CHECKSUM_EN
                        r_checksum        <= 8'd0;
`endif
                    end
                end

                S_LEN: begin
                    if (w_accept) begin
                        r_count <= i_byte;
                        if (i_byte == 8'd0 || i_byte > MAX_LEN) begin
                            r_state        <= S_ERROR;
                            r_byte_ready   <= 1'b0;
                            r_error        <= 1'b1;
                            r_program_mode <= 1'b0;
                            r_cpu_hold     <= 1'b1;
                        end else begin
                            r_state <= S_HIGH;
                        end
                    end
                end

                S_HIGH: begin
                    if (w_accept) begin
                        r_program_data[15:8] <= i_byte;
`ifdef LOADER_CHECKSUM_EN
                        r_checksum           <= r_checksum + i_byte;
`endif
                        r_state              <= S_LOW;
                    end
                end

                S_LOW: begin
                    if (w_accept) begin
                        r_program_data[7:0] <= i_byte;
`ifdef LOADER_CHECKSUM_EN
                        r_checksum          <= r_checksum + i_byte;
`endif
                        // Strobe is raised here so it is visible in the very
                        // next cycle, with address and data already settled.
                        r_state             <= S_WRITE;
                        r_byte_ready        <= 1'b0;
                        r_write_enable      <= 1'b1;
                    end
                end

                S_WRITE: begin
                    r_write_enable    <= 1'b0;
                    r_program_address <= r_program_address + 8'd1;
                    r_count           <= r_count - 8'd1;
                    // r_count still holds the pre-decrement value here, so a
                    // value of 1 means this was the last word.
                    if (r_count != 8'd1) begin
                        r_state      <= S_HIGH;
                        r_byte_ready <= 1'b1;
                    end else begin
`ifdef LOADER_CHECKSUM_EN
                        r_state      <= S_CHECK;
                        r_byte_ready <= 1'b1;
`else
                        r_state        <= S_DONE;
                        r_done         <= 1'b1;
                        r_program_mode <= 1'b0;
                        r_cpu_hold     <= 1'b0;
`endif
                    end
                end

`ifdef LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (w_accept) begin
                        r_byte_ready   <= 1'b0;
                        r_program_mode <= 1'b0;
                        if (i_byte == r_checksum) begin
                            r_state    <= S_DONE;
                            r_done     <= 1'b1;
                            r_cpu_hold <= 1'b0;
                        end else begin
                            r_state    <= S_ERROR;
                            r_error    <= 1'b1;
                            r_cpu_hold <= 1'b1;
                        end
                    end
                end
`endif

                default: begin
                    r_state        <= S_IDLE;
                    r_byte_ready   <= 1'b0;
                    r_write_enable <= 1'b0;
                end
            endcase
        end
    end

    assign o_byte_ready      = r_byte_ready;
    assign o_program_mode    = r_program_mode;
    assign o_program_address = r_program_address;
    assign o_program_data    = r_program_data;
    assign o_write_enable    = r_write_enable;
    assign o_cpu_hold        = r_cpu_hold;
    assign o_done            = r_done;
    assign o_error           = r_error;

endmodule
